// File: rtl/toggle_event_receiver_pkg.sv
// ----------------------------------------------------------------------------
// toggle_event_receiver_pkg
// Shared constants for the toggle event receiver:
//   CNT_W_DEFAULT  default width of the pending-event counter
//   PRIME_CYCLES   prime counter load value after reset
//   ST_PRIME/ST_RUN state encoding of the receiver FSM
// ----------------------------------------------------------------------------
package toggle_event_receiver_pkg;

    localparam int CNT_W_DEFAULT = 4;
    localparam int PRIME_CYCLES  = 3;

    localparam logic [0:0] ST_PRIME = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    typedef logic [1:0] prime_cnt_t;

endpackage

// File: rtl/toggle_event_receiver_if.sv
// ----------------------------------------------------------------------------
// toggle_event_receiver_if
// Event handshake between the receiver (master) and its consumer (slave).
//   evt_valid  receiver -> consumer  at least one event pending
//   pending    receiver -> consumer  registered count of undelivered events
//   overflow   receiver -> consumer  sticky: an event was lost
//   evt_ready  consumer -> receiver  consumer takes one event this cycle
//   ovf_clr    consumer -> receiver  clear the overflow flag
// ----------------------------------------------------------------------------
interface toggle_event_receiver_if
    import toggle_event_receiver_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
);

    logic             evt_valid;
    logic [CNT_W-1:0] pending;
    logic             overflow;
    logic             evt_ready;
    logic             ovf_clr;

    modport master (
        output evt_valid,
        output pending,
        output overflow,
        input  evt_ready,
        input  ovf_clr
    );

    modport slave (
        input  evt_valid,
        input  pending,
        input  overflow,
        output evt_ready,
        output ovf_clr
    );

endinterface

// File: rtl/toggle_sync2.sv
// ----------------------------------------------------------------------------
// toggle_sync2
// Two-flop synchronizer for a single asynchronous level.
//   clk    sampling clock
//   reset  synchronous active-high reset, clears both flops
//   d      asynchronous input level
//   q      synchronized level, two clocks behind d
// ----------------------------------------------------------------------------
module toggle_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of its neighbour; with = the chain would collapse.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/toggle_event_receiver.sv
// ----------------------------------------------------------------------------
// toggle_event_receiver
// Turns every level change of a remote toggle line into one queued event and
// hands events to a consumer with a valid/ready handshake.
//   clk     single clock
//   reset   synchronous active-high reset
//   T_in    asynchronous toggle line, each level change is one event
//   evt_if  master side of the event handshake (evt_valid, pending, overflow
//           out; evt_ready, ovf_clr in)
//   Q, Qn   synchronized T_in level and its inverse
// Latency: a T_in change stable before edge n is counted at edge n+3
// (two sync flops plus one registered edge pulse).
// ----------------------------------------------------------------------------
module toggle_event_receiver
    import toggle_event_receiver_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            T_in,
    toggle_event_receiver_if.master         evt_if,
    output logic                            Q,
    output logic                            Qn
);

    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    logic             s2;
    logic             s3;
    logic             edge_q;
    logic [0:0]       state;
    prime_cnt_t       prime_cnt;
    logic [CNT_W-1:0] pending_q;
    logic [CNT_W-1:0] pending_nxt;
    logic             overflow_q;
    logic             ovf_set;
    logic             accept;

    toggle_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (T_in),
        .q     (s2)
    );

    assign Q  = s2;
    assign Qn = ~s2;

    // Sync tail, edge pulse and prime sequencing. While priming, the chain
    // fills with the post-reset T_in level; any difference it shows against
    // the cleared s3 is not a real event, so edges are only captured in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            s3        <= 1'b0;
            edge_q    <= 1'b0;
            state     <= ST_PRIME;
            prime_cnt <= prime_cnt_t'(PRIME_CYCLES);
        end else begin
            s3     <= s2;
            edge_q <= (state == ST_RUN) && (s2 != s3);
            case (state)
                ST_PRIME: begin
                    if (prime_cnt == '0) begin
                        state <= ST_RUN;
                    end else begin
                        prime_cnt <= prime_cnt - 2'd1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // evt_valid is decoded from the registered count only.
    assign evt_if.evt_valid = (pending_q != '0);
    assign accept           = evt_if.evt_valid & evt_if.evt_ready;

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        pending_nxt = pending_q;
        ovf_set     = 1'b0;
        case ({edge_q, accept})
            2'b10: begin
                if (pending_q == PEND_MAX) begin
                    ovf_set = 1'b1;
                end else begin
                    pending_nxt = pending_q + CNT_W'(1);
                end
            end
            // accept implies pending_q != 0, so this never wraps
            2'b01:   pending_nxt = pending_q - CNT_W'(1);
            // detect plus accept in one cycle cancel out
            default: pending_nxt = pending_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q <= pending_nxt;
            // a new loss outranks a simultaneous clear
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end else if (evt_if.ovf_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign evt_if.pending  = pending_q;
    assign evt_if.overflow = overflow_q;

endmodule

// File: tb/tb_toggle_event_receiver.sv
// ----------------------------------------------------------------------------
// tb_toggle_event_receiver
// Directed bench for toggle_event_receiver with CNT_W = 4.
// ----------------------------------------------------------------------------
module tb_toggle_event_receiver;
    import toggle_event_receiver_pkg::*;

    localparam int CNT_W = 4;

    logic clk;
    logic reset;
    logic T_in;
    logic Q;
    logic Qn;

    int passed;
    int total;
    int accepted;
    int toggles;

    toggle_event_receiver_if #(.CNT_W(CNT_W)) evt_if ();

    toggle_event_receiver #(.CNT_W(CNT_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .T_in   (T_in),
        .evt_if (evt_if),
        .Q      (Q),
        .Qn     (Qn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
            $error("check %s did not hold", tag);
        end
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        accepted = 0;
        toggles  = 0;

        // Reset with T_in already high.
        reset            = 1'b1;
        T_in             = 1'b1;
        evt_if.evt_ready = 1'b0;
        evt_if.ovf_clr   = 1'b0;
        tick(2);
        check("rst_pending",  evt_if.pending,   0);
        check("rst_valid",    evt_if.evt_valid, 0);
        check("rst_overflow", evt_if.overflow,  0);
        check("rst_q",        Q,                0);
        check("rst_qn",       Qn,               1);

        // T_in held high for 10 cycles after reset: primed away, no event.
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_pending", evt_if.pending,   0);
            check("hold_valid",   evt_if.evt_valid, 0);
        end
        check("hold_q",  Q,  1);
        check("hold_qn", Qn, 0);

        // Single toggle: counted at the fourth edge, then one accept.
        T_in = 1'b0;
        tick(3);
        check("lat_pending_e2", evt_if.pending, 0);
        tick();
        check("lat_pending_e3", evt_if.pending,   1);
        check("lat_valid_e3",   evt_if.evt_valid, 1);
        evt_if.evt_ready = 1'b1;
        tick();
        evt_if.evt_ready = 1'b0;
        check("acc_pending", evt_if.pending,   0);
        check("acc_valid",   evt_if.evt_valid, 0);

        // 16 toggles, no consumer: saturate at 15 and flag overflow.
        for (int i = 0; i < 16; i++) begin
            T_in = ~T_in;
            tick(4);
            check("sat_pending",  evt_if.pending,  (i + 1 > 15) ? 15 : i + 1);
            check("sat_overflow", evt_if.overflow, (i == 15) ? 1 : 0);
        end
        evt_if.ovf_clr = 1'b1;
        tick();
        evt_if.ovf_clr = 1'b0;
        check("clr_overflow", evt_if.overflow, 0);
        check("clr_pending",  evt_if.pending,  15);

        // Clear and a new overflow in the same cycle: set wins.
        T_in = ~T_in;
        tick(3);
        evt_if.ovf_clr = 1'b1;
        tick();
        evt_if.ovf_clr = 1'b0;
        check("setwin_overflow", evt_if.overflow, 1);
        check("setwin_pending",  evt_if.pending,  15);

        // Drain everything, then ready with nothing pending.
        evt_if.evt_ready = 1'b1;
        tick(15);
        check("drain_pending", evt_if.pending, 0);
        tick();
        check("empty_pending", evt_if.pending,   0);
        check("empty_valid",   evt_if.evt_valid, 0);
        evt_if.evt_ready = 1'b0;
        evt_if.ovf_clr   = 1'b1;
        tick();
        evt_if.ovf_clr   = 1'b0;
        check("drain_overflow", evt_if.overflow, 0);

        // pending = 2, then detect coincides with the first accept.
        T_in = ~T_in;
        tick(4);
        T_in = ~T_in;
        tick(4);
        check("mix_pending_0", evt_if.pending, 2);
        T_in = ~T_in;
        tick(3);
        evt_if.evt_ready = 1'b1;
        tick();
        check("mix_pending_1", evt_if.pending, 2);
        tick();
        check("mix_pending_2", evt_if.pending, 1);
        tick();
        check("mix_pending_3", evt_if.pending, 0);
        check("mix_overflow",  evt_if.overflow, 0);
        evt_if.evt_ready = 1'b0;

        // pending = 5, then a one-cycle reset discards it.
        for (int i = 0; i < 5; i++) begin
            T_in = ~T_in;
            tick(4);
        end
        check("pre_rst_pending", evt_if.pending, 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_pending", evt_if.pending,   0);
        check("mid_rst_valid",   evt_if.evt_valid, 0);
        check("mid_rst_state",   dut.state,        ST_PRIME);
        check("mid_rst_qn",      Qn,               1);
        tick(4);
        check("prime_pending", evt_if.pending, 0);
        check("prime_state",   dut.state,      ST_RUN);
        T_in = ~T_in;
        tick(4);
        check("resume_pending", evt_if.pending, 1);
        evt_if.evt_ready = 1'b1;
        tick();
        evt_if.evt_ready = 1'b0;
        check("resume_drain", evt_if.pending, 0);

        // Random toggles at least 3 cycles apart, random consumer.
        for (int i = 0; i < 30; i++) begin
            T_in = ~T_in;
            toggles++;
            repeat ($urandom_range(3, 5)) begin
                evt_if.evt_ready = ($urandom_range(0, 3) != 0);
                if (evt_if.evt_valid && evt_if.evt_ready) accepted++;
                tick();
            end
        end
        repeat (20) begin
            evt_if.evt_ready = 1'b1;
            if (evt_if.evt_valid && evt_if.evt_ready) accepted++;
            tick();
        end
        evt_if.evt_ready = 1'b0;
        check("rand_accepted", accepted,        toggles);
        check("rand_overflow", evt_if.overflow, 0);
        check("rand_pending",  evt_if.pending,  0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
